// File: rtl/adc_spi_capture.sv
// Serial ADC capture front-end: CS/SCLK framing, MSB-first shift-in, eoc pulse, CS-high quiet time.
// Optional feature macro: ADC_OFFSET_EN (saturating offset subtraction on the captured sample).
module adc_spi_capture #(
    parameter int                    DATA_WIDTH   = 12,
    parameter int                    FRAME_BITS   = 16,
    parameter int                    CLK_DIV      = 2,
    parameter int                    CONV_CYCLES  = 4,
    parameter int                    QUIET_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] OFFSET       = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  eoc_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  adc_cs_no,
    output logic                  adc_sclk_o,
    input  logic                  adc_sdata_i
);

    localparam int CNT_MAX_A = (CONV_CYCLES > QUIET_CYCLES) ? CONV_CYCLES : QUIET_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > 2 * CLK_DIV) ? CNT_MAX_A : 2 * CLK_DIV;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int BW        = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);
    localparam logic [CW-1:0] HALF       = CW'(CLK_DIV);
    localparam logic [CW-1:0] PER_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

`ifdef ADC_OFFSET_EN
    localparam logic [DATA_WIDTH-1:0] OFFSET_EFF = OFFSET;
`else
    localparam logic [DATA_WIDTH-1:0] OFFSET_EFF = OFFSET & {DATA_WIDTH{1'b0}};
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_QUIET = 3'd4
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] sat_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : {DATA_WIDTH{1'b0}};
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  eoc_q, eoc_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;

    // Next-state, counter, capture and output decode; outputs lag the state by one edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        busy_d  = (state_q != S_IDLE);
        eoc_d   = (state_q == S_DONE);
        cs_n_d  = !((state_q == S_CONV) || (state_q == S_SHIFT));
        sclk_d  = !((state_q == S_SHIFT) && (cnt_q < HALF));
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CONV;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = {CW{1'b0}};
                    bit_d   = {BW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_SHIFT: begin
                // Sample on the edge that raises SCLK; the ADC changed data on the falling edge.
                if (cnt_q == HALF) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], adc_sdata_i};
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == PER_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (bit_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + {{(BW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_QUIET;
                cnt_d   = {CW{1'b0}};
                data_d  = sat_sub(shift_q, OFFSET_EFF);
            end
            S_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= {BW{1'b0}};
            shift_q <= {DATA_WIDTH{1'b0}};
            data_q  <= {DATA_WIDTH{1'b0}};
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            eoc_q   <= eoc_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
        end
    end

    assign busy_o     = busy_q;
    assign eoc_o      = eoc_q;
    assign data_o     = data_q;
    assign adc_cs_no  = cs_n_q;
    assign adc_sclk_o = sclk_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Randomized scoreboard bench for adc_spi_capture with a behavioural ADC and frame-timing model.
`timescale 1ns/1ps
module tb_adc_spi_capture;
    localparam int DW     = 12;
    localparam int FB     = 16;
    localparam int CD     = 2;
    localparam int CC     = 4;
    localparam int QC     = 8;
    localparam int L      = 1 + CC + 2 * CD * FB;
    localparam int PERIOD = L + 1 + QC;
`ifdef ADC_OFFSET_EN
    localparam logic [DW-1:0] OFF = 12'h020;
`else
    localparam logic [DW-1:0] OFF = 12'h000;
`endif

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic          busy_o;
    logic          eoc_o;
    logic [DW-1:0] data_o;
    logic          adc_cs_no;
    logic          adc_sclk_o;
    logic          adc_sdata_i = 1'b0;

    adc_spi_capture #(
        .DATA_WIDTH(DW), .FRAME_BITS(FB), .CLK_DIV(CD),
        .CONV_CYCLES(CC), .QUIET_CYCLES(QC), .OFFSET(OFF)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
        .eoc_o(eoc_o), .data_o(data_o), .adc_cs_no(adc_cs_no),
        .adc_sclk_o(adc_sclk_o), .adc_sdata_i(adc_sdata_i)
    );

    typedef struct {
        int            eoc_edge;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [FB-1:0] forced_q[$];
    logic [FB-1:0] frame_word = '0;
    logic [DW-1:0] exp_hold;
    int            total, bad;
    int            edge_cnt;
    int            last_acc;
    int            ready_edge;
    bit            acc_valid;

    initial begin
        clk      = 1'b0;
        edge_cnt = 0;
        forever begin
            #5 edge_cnt++;
            clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [DW-1:0] ref_data(input logic [FB-1:0] w);
        logic [DW-1:0] s;
        s = w[DW-1:0];
        return (s >= OFF) ? (s - OFF) : 12'h000;
    endfunction

    // Behavioural ADC: shifts the frame out MSB first on SCLK falling edges, counts rising edges.
    logic prev_sclk = 1'b1;
    logic prev_cs   = 1'b1;
    int   idx       = FB - 1;
    int   rises     = 0;
    int   frame_rises = 0;
    always @(adc_sclk_o or adc_cs_no) begin
        if (adc_cs_no) begin
            if (!prev_cs) frame_rises = rises;
            rises = 0;
            idx   = FB - 1;
        end else begin
            if (prev_sclk && !adc_sclk_o) begin
                adc_sdata_i = (idx >= 0) ? frame_word[idx] : 1'b0;
                idx--;
            end
            if (!prev_sclk && adc_sclk_o) rises++;
        end
        prev_sclk = adc_sclk_o;
        prev_cs   = adc_cs_no;
    end

    task automatic accept();
        logic [31:0]   r;
        logic [FB-1:0] w;
        exp_t          it;
        if (forced_q.size() > 0) begin
            w = forced_q.pop_front();
        end else begin
            r = $urandom;
            w = r[FB-1:0];
        end
        frame_word  = w;
        it.eoc_edge = edge_cnt + L;
        it.data     = ref_data(w);
        sb_q.push_back(it);
        last_acc   = edge_cnt;
        acc_valid  = 1'b1;
        ready_edge = edge_cnt + PERIOD;
    endtask

    task automatic step(input logic s);
        @(negedge clk);
        start_i = s;
        @(posedge clk);
        if (s && !rst_i && (edge_cnt >= ready_edge)) accept();
    endtask

    task automatic apply_reset(input int ncyc);
        rst_i   = 1'b1;
        start_i = 1'b0;
        #1;
        sb_q.delete();
        acc_valid = 1'b0;
        exp_hold  = '0;
        check("rst_cs_n", adc_cs_no, 1);
        check("rst_sclk", adc_sclk_o, 1);
        check("rst_eoc", eoc_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", data_o, 0);
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        rst_i      = 1'b0;
        ready_edge = 0;
    endtask

    // Monitor: per-cycle framing checks and scoreboard pop on every eoc pulse.
    always @(negedge clk) begin
        int   e, rel, sh;
        logic exp_busy, exp_cs_n, exp_sclk;
        exp_t h;
        if (!rst_i) begin
            e        = edge_cnt;
            rel      = e - last_acc;
            sh       = rel - 1 - CC;
            exp_busy = acc_valid && (rel >= 1) && (rel <= L + QC);
            exp_cs_n = !(acc_valid && (rel >= 1) && (rel <= L - 1));
            exp_sclk = !(acc_valid && (sh >= 0) && (sh < 2 * CD * FB) && ((sh % (2 * CD)) < CD));
            check("busy", busy_o, exp_busy);
            check("cs_n", adc_cs_no, exp_cs_n);
            check("sclk", adc_sclk_o, exp_sclk);
            if (eoc_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_eoc", 1, 0);
                end else begin
                    h = sb_q.pop_front();
                    check("eoc_edge", e, h.eoc_edge);
                    check("eoc_data", data_o, h.data);
                    check("sclk_rises", frame_rises, FB);
                    exp_hold = h.data;
                end
            end else begin
                check("data_hold", data_o, exp_hold);
                if ((sb_q.size() > 0) && (e > sb_q[0].eoc_edge)) begin
                    check("missing_eoc", e, sb_q[0].eoc_edge);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        start_i    = 1'b0;
        rst_i      = 1'b0;
        total      = 0;
        bad        = 0;
        acc_valid  = 1'b0;
        last_acc   = 0;
        ready_edge = 0;
        exp_hold   = '0;
        apply_reset(3);

        // Single frame plus starts that land while busy, then a start exactly when idle again.
        forced_q.push_back(16'h0A5C);
        forced_q.push_back(16'h3010);
        for (int r = 0; r <= 200; r++) step((r == 0) || (r == 10) || (r == 72) || (r == 78));

        // Reset in the middle of SHIFT, then a normal frame.
        step(1'b1);
        repeat (30) step(1'b0);
        #1 apply_reset(3);
        step(1'b1);
        repeat (PERIOD + 10) step(1'b0);

        // Start held high: back-to-back frames at the minimum period.
        forced_q.push_back(16'hF800);
        repeat (4 * PERIOD) step(1'b1);
        repeat (PERIOD) step(1'b0);

        // Sparse random starts.
        repeat (600) step($urandom_range(0, 7) == 0);
        repeat (PERIOD + 5) step(1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_spi_capture.md
# adc_spi_capture

- Serial ADC front-end for the 3LFCC sampling path.
- A one-cycle `start_i` pulse (driven by the sampling timer's `trigger_o`) opens a conversion frame on the ADC's SPI lines.
- The block shifts in one sample, then presents it on `data_o` with a one-cycle `eoc_o` pulse. That pulse feeds the sampling timer's `eoc_i` and the control datapath.
- A quiet period follows each frame, guaranteeing the ADC's minimum CS-high time before the next start is accepted.

## Interface
Parameters:
- `DATA_WIDTH`, 12: sample width in bits.
- `FRAME_BITS`, 16: SCLK cycles per frame. Must be ≥ `DATA_WIDTH`. The sample is the last `DATA_WIDTH` bits shifted in, MSB first.
- `CLK_DIV`, 2: clk_i cycles per SCLK half-period. Must be ≥ 1.
- `CONV_CYCLES`, 4: clk_i cycles CS is low before the first SCLK falling edge. Must be ≥ 1.
- `QUIET_CYCLES`, 8: clk_i cycles CS stays high after a frame before a new start is accepted. Must be ≥ 1.
- `OFFSET`, 0: unsigned offset, `DATA_WIDTH` bits. Used only with `ADC_OFFSET_EN`.

Ports:
- `clk_i`, input, 1: system clock.
- `rst_i`, input, 1: reset; asynchronous, active-high.
- `start_i`, input, 1: conversion request pulse. Sampled only in IDLE.
- `busy_o`, input/output direction output, 1: high in every state except IDLE.
- `eoc_o`, output, 1: end-of-conversion pulse, exactly one cycle.
- `data_o`, output, `DATA_WIDTH`: last completed sample. Holds its value between conversions.
- `adc_cs_no`, output, 1: ADC chip select, active-low.
- `adc_sclk_o`, output, 1: SPI clock. Idles high (CPOL=1).
- `adc_sdata_i`, input, 1: ADC serial data, already synchronous to `clk_i`.

## Operation
States: IDLE → CONV → SHIFT → DONE → QUIET → IDLE.
- **IDLE:** `adc_cs_no`=1, `adc_sclk_o`=1. `start_i`=1 moves to CONV on the next edge.
- **CONV:** `adc_cs_no`=0 for `CONV_CYCLES` cycles, then SHIFT.
- **SHIFT:** `FRAME_BITS` SCLK periods. Each period is `adc_sclk_o`=0 for `CLK_DIV` cycles, then 1 for `CLK_DIV` cycles.
  - `adc_sdata_i` is captured into the shift register in the clk cycle whose edge drives `adc_sclk_o` from 0 to 1.
  - After the last high half, go to DONE.
- **DONE (1 cycle):**
  - `adc_cs_no`=1 and `eoc_o`=1.
  - `data_o` updates on this same edge, so it is valid while `eoc_o`=1.
  - Next state is QUIET.
- **QUIET:** `QUIET_CYCLES` cycles with CS high. `start_i` is ignored. Then IDLE.
- A `start_i` pulse in any state other than IDLE is dropped: no queuing and no error flag.
- Counters are sized with `$clog2` of their maximum plus one. No counter wraps; each is cleared on state entry.
- Reset values: `busy_o`=0, `eoc_o`=0, `data_o`=0, `adc_cs_no`=1, `adc_sclk_o`=1, state=IDLE, shift register=0.
- Reset mid-frame: outputs return to their reset values immediately (asynchronously). No `eoc_o` is produced and `data_o` is cleared to 0.

## Timing
- Let `start_i` be sampled high at edge 0.
  - CS falls at edge 1.
  - The first SCLK falling edge is at edge 1+`CONV_CYCLES`.
  - `eoc_o`=1 and CS rises at edge L = 1 + `CONV_CYCLES` + 2·`CLK_DIV`·`FRAME_BITS`. With the default parameters, L = 69.
- `busy_o` rises at edge 1 and falls at edge L+1+`QUIET_CYCLES`.
- Minimum start-to-start period is L+1+`QUIET_CYCLES` cycles, 78 with the default parameters.
- `adc_sclk_o` and `adc_cs_no` come straight from flops, with no combinational path from inputs.
- If `start_i` and the transition into IDLE occur on the same edge, the start is not accepted. A start must be seen while already in IDLE.

## Configuration
- `ADC_OFFSET_EN` defined:
  - `data_o` = captured sample − `OFFSET`, saturated at 0 (no underflow wrap).
  - The subtraction is registered into `data_o` at DONE, so latency is unchanged.
- `ADC_OFFSET_EN` undefined: `data_o` = raw captured sample; `OFFSET` is unused.

## Test plan
- **Reset:** assert `rst_i` for 3 cycles → all outputs at the reset values above, `busy_o`=0.
- **Single conversion, default parameters:** ADC model returns 0x0A5C in a 16-bit frame (4 leading zeros).
  - `data_o`=0xA5C and `eoc_o` high exactly at edge 69, for one cycle.
  - 16 SCLK rising edges while CS is low.
- **Start while busy:** pulse `start_i` at edges 10 and 72.
  - Only one frame occurs; `busy_o` falls at edge 78.
  - A new pulse at edge 78 starts a frame with CS falling at edge 79.
- **Reset mid-SHIFT (edge 30):** CS=1 and SCLK=1 immediately, `eoc_o` never pulses, `data_o`=0. A subsequent start runs a normal frame.
- **`start_i` held high continuously:** conversions repeat every 78 cycles, each producing exactly one `eoc_o`.
- **`ADC_OFFSET_EN` with `OFFSET`=0x020:**
  - sample 0x010 → `data_o`=0x000.
  - sample 0x800 → `data_o`=0x7E0.
